// File: rtl/dlsc_demosaic_vng6_sequencer.sv
// Sequencer for the VNG6 shift-register/ROM datapath: state index, push strobe,
// datapath stall (clk_en), and the valid/last pipeline that lines up with the datapath result.
module dlsc_demosaic_vng6_sequencer #(
    parameter int unsigned STATES    = 12,
    parameter logic [15:0] PUSH_MASK = 16'h0041,
    parameter int unsigned OUT_STATE = 11,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned XB        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          clk_en,
    output logic [3:0]    st,
    output logic          push,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          out_last,
    output logic [XB-1:0] col
);

    localparam logic [3:0]    ST_LAST  = 4'(STATES - 1);
    localparam logic [3:0]    ST_OUT   = 4'(OUT_STATE);
    localparam logic [XB-1:0] COL_LAST = XB'(WIDTH - 1);

    logic [3:0]       st_next;
    logic             need_in;
    logic             stall_in;
    logic             stall_out;
    logic             issue;
    logic             xfer;
    logic [XB-1:0]    col_in;
    logic [LATENCY:0] vld_pipe;
    logic [LATENCY:0] lst_pipe;

    // Stall decision and next slot state; an output stall wins over a waiting input word.
    always_comb begin
        st_next   = st;
        need_in   = PUSH_MASK[st];
        push      = need_in & ~rst;
        stall_in  = need_in & ~in_valid;
        stall_out = out_valid & ~out_ready;
        clk_en    = ~rst & ~stall_in & ~stall_out;
        in_ready  = clk_en & need_in;
        issue     = clk_en & (st == ST_OUT);
        xfer      = out_valid & out_ready;
        if (clk_en) begin
            st_next = (st == ST_LAST) ? 4'd0 : st + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= 4'd0;
            col_in   <= '0;
            col      <= '0;
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            st <= st_next;
            if (clk_en) begin
                vld_pipe <= {vld_pipe[LATENCY-1:0], issue};
                lst_pipe <= {lst_pipe[LATENCY-1:0], issue & (col_in == COL_LAST)};
                if (issue) begin
                    col_in <= (col_in == COL_LAST) ? '0 : col_in + XB'(1);
                end
            end else if (xfer) begin
                // Result taken while the datapath is starved: retire it so it is not re-sent.
                vld_pipe[LATENCY] <= 1'b0;
                lst_pipe[LATENCY] <= 1'b0;
            end
            if (xfer) begin
                col <= (col == COL_LAST) ? '0 : col + XB'(1);
            end
        end
    end

    assign out_valid = vld_pipe[LATENCY];
    assign out_last  = lst_pipe[LATENCY];

endmodule
